// File: rtl/proc_pkg.sv
// Shared definitions for the 9-bit processor and its instruction sequencer:
// opcode field values (bits 8:6 of an instruction word) and the sequencer
// state encoding.
package proc_pkg;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_FETCH_IMM,
        ST_IMM_LATCH,
        ST_ISSUE,
        ST_OPER,
        ST_WAIT,
        ST_PAUSE,
        ST_HALT,
        ST_FAULT
    } seq_state_e;

    function automatic logic [2:0] opcode_of(input logic [8:0] word);
        return word[8:6];
    endfunction

endpackage

// File: rtl/proc_sequencer.sv
// Autonomous instruction feeder for the 9-bit processor core. Reads program
// words from a ROM with one cycle of read latency, supplies the MVI immediate
// in the cycle after the issue strobe, stops on HALT, and guards each
// instruction with a completion watchdog.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | quiet after reset, waits for Start
// FETCH     | PC on MemAddr, ROM word arrives next cycle
// DECODE    | latch instruction, advance PC, dispatch on opcode
// FETCH_IMM | PC on MemAddr for the MVI immediate
// IMM_LATCH | latch immediate, advance PC
// ISSUE     | instruction on ProcDIN with ProcRun high, watchdog cleared
// OPER      | immediate (MVI) or zero on ProcDIN, core samples it
// WAIT      | wait for ProcDone, count retirements, watchdog running
// PAUSE     | single-step hold until StepNext or Step cleared
// HALT      | HALT opcode consumed, Start re-launches
// FAULT     | watchdog expired, only Resetn leaves
module proc_sequencer
    import proc_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int TIMEOUT = 15
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    input  logic [ADDR_W-1:0] StartAddr,
    input  logic              Step,
    input  logic              StepNext,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic [8:0]        MemData,
    output logic [8:0]        ProcDIN,
    output logic              ProcRun,
    input  logic              ProcDone,
    output logic              Busy,
    output logic              Halted,
    output logic              Fault,
    output logic [7:0]        InstrCount
);

    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [8:0]        ir_q, ir_d;
    logic [8:0]        imm_q, imm_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [7:0]        count_q, count_d;
    logic [WD_W-1:0]   wd_inc;
    logic [8:0]        din;

    assign wd_inc = wd_q + 1'b1;

    // State and datapath registers, synchronous active-low reset.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            imm_q   <= '0;
            wd_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            imm_q   <= imm_d;
            wd_q    <= wd_d;
            count_q <= count_d;
        end
    end

    // Next-state and register updates; MemData/ProcDone only feed registers.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        imm_d   = imm_q;
        wd_d    = wd_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (Start) begin
                    state_d = ST_FETCH;
                    pc_d    = StartAddr;
                    count_d = '0;
                end
            end
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                ir_d = MemData;
                pc_d = pc_q + 1'b1;
                case (opcode_of(MemData))
                    OP_HALT: state_d = ST_HALT;
                    OP_MVI:  state_d = ST_FETCH_IMM;
                    default: state_d = ST_ISSUE;
                endcase
            end
            ST_FETCH_IMM: state_d = ST_IMM_LATCH;
            ST_IMM_LATCH: begin
                imm_d   = MemData;
                pc_d    = pc_q + 1'b1;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                wd_d    = '0;
                state_d = ST_OPER;
            end
            ST_OPER: state_d = ST_WAIT;
            ST_WAIT: begin
                if (ProcDone) begin
                    if (count_q != 8'hFF) count_d = count_q + 8'd1;
                    state_d = Step ? ST_PAUSE : ST_FETCH;
                end else begin
                    wd_d = wd_inc;
                    if (wd_inc == WD_W'(TIMEOUT)) state_d = ST_FAULT;
                end
            end
            ST_PAUSE: begin
                if (StepNext || !Step) state_d = ST_FETCH;
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Word on the core's DIN: instruction during ISSUE, MVI immediate during OPER.
    always_comb begin
        din = '0;
        case (state_q)
            ST_ISSUE: din = ir_q;
            ST_OPER:  if (opcode_of(ir_q) == OP_MVI) din = imm_q;
            default:  din = '0;
        endcase
    end

    assign ProcDIN    = din;
    assign ProcRun    = (state_q == ST_ISSUE);
    assign MemAddr    = pc_q;
    assign Halted     = (state_q == ST_HALT);
    assign Fault      = (state_q == ST_FAULT);
    assign Busy       = !((state_q == ST_IDLE) || (state_q == ST_HALT) || (state_q == ST_FAULT));
    assign InstrCount = count_q;

endmodule

// File: tb/tb_proc_sequencer.sv
module tb_proc_sequencer;
    import proc_pkg::*;

    localparam int ADDR_W    = 5;
    localparam int TIMEOUT   = 15;
    localparam int DEPTH     = 32;
    localparam int ADD_EXTRA = 2;
    localparam logic [8:0] HALTW = 9'h1C0;

    logic              Clock = 1'b0;
    logic              Resetn = 1'b0;
    logic              Start = 1'b0;
    logic [ADDR_W-1:0] StartAddr = '0;
    logic              Step = 1'b0;
    logic              StepNext = 1'b0;
    logic [ADDR_W-1:0] MemAddr;
    logic [8:0]        MemData;
    logic [8:0]        ProcDIN;
    logic              ProcRun;
    logic              ProcDone;
    logic              Busy;
    logic              Halted;
    logic              Fault;
    logic [7:0]        InstrCount;

    int total = 0;
    int bad   = 0;

    always #5 Clock = ~Clock;

    proc_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .Clock(Clock), .Resetn(Resetn), .Start(Start), .StartAddr(StartAddr),
        .Step(Step), .StepNext(StepNext), .MemAddr(MemAddr), .MemData(MemData),
        .ProcDIN(ProcDIN), .ProcRun(ProcRun), .ProcDone(ProcDone), .Busy(Busy),
        .Halted(Halted), .Fault(Fault), .InstrCount(InstrCount)
    );

    // program ROM, one cycle read latency
    logic [8:0] rom [DEPTH];
    always @(posedge Clock) MemData <= rom[MemAddr];

    // behavioural core: takes the word on ProcRun, the operand at the end of
    // the next cycle, then raises Done (ADD/SUB hold Done low ADD_EXTRA more cycles)
    logic [8:0] creg [8];
    logic [8:0] cir = '0;
    int         cphase = 0;
    int         ccnt = 0;
    logic       cdone = 1'b1;
    bit         stuck0 = 1'b0;
    assign ProcDone = cdone & ~stuck0;

    always @(posedge Clock) begin
        if (!Resetn) begin
            cphase <= 0;
            cdone  <= 1'b1;
            for (int i = 0; i < 8; i++) creg[i] <= '0;
        end else if (ProcRun) begin
            cir    <= ProcDIN;
            cphase <= 1;
            cdone  <= 1'b0;
        end else if (cphase == 1) begin
            case (cir[8:6])
                OP_MV:  creg[cir[5:3]] <= creg[cir[2:0]];
                OP_MVI: creg[cir[5:3]] <= ProcDIN;
                OP_ADD: creg[cir[5:3]] <= creg[cir[5:3]] + creg[cir[2:0]];
                OP_SUB: creg[cir[5:3]] <= creg[cir[5:3]] - creg[cir[2:0]];
                default: ;
            endcase
            if (cir[8:6] == OP_ADD || cir[8:6] == OP_SUB) begin
                ccnt   <= ADD_EXTRA;
                cphase <= 2;
            end else begin
                cdone  <= 1'b1;
                cphase <= 0;
            end
        end else if (cphase == 2) begin
            if (ccnt <= 1) begin
                cdone  <= 1'b1;
                cphase <= 0;
            end
            ccnt <= ccnt - 1;
        end
    end

    // issue monitor: issued words and the DIN value in the cycle after each MVI issue
    int         runs = 0;
    logic       prev_mvi = 1'b0;
    logic [8:0] issued_q [$];
    logic [8:0] imm_seen_q [$];
    always @(negedge Clock) begin
        if (Resetn) begin
            if (prev_mvi) imm_seen_q.push_back(ProcDIN);
            prev_mvi = ProcRun && (ProcDIN[8:6] == OP_MVI);
            if (ProcRun) begin
                runs++;
                issued_q.push_back(ProcDIN);
            end
        end
    end

    // instruction-level reference: walks the ROM, computes results and cycle budget
    logic [8:0] mreg [8];
    int         m_cnt, m_cyc;
    logic [8:0] m_issue [$];
    logic [8:0] m_imm [$];

    task automatic ref_run(input int start);
        int pc;
        logic [8:0] w, imm;
        pc = start; m_cnt = 0; m_cyc = 0;
        m_issue.delete(); m_imm.delete();
        for (int r = 0; r < 8; r++) mreg[r] = '0;
        for (int guard = 0; guard < 300; guard++) begin
            w = rom[pc]; pc = (pc + 1) % DEPTH; m_cyc += 2;
            if (w[8:6] == OP_HALT) break;
            imm = '0;
            if (w[8:6] == OP_MVI) begin
                imm = rom[pc]; pc = (pc + 1) % DEPTH; m_cyc += 2;
                m_imm.push_back(imm);
            end
            m_issue.push_back(w);
            case (w[8:6])
                OP_MV:  mreg[w[5:3]] = mreg[w[2:0]];
                OP_MVI: mreg[w[5:3]] = imm;
                OP_ADD: mreg[w[5:3]] = mreg[w[5:3]] + mreg[w[2:0]];
                OP_SUB: mreg[w[5:3]] = mreg[w[5:3]] - mreg[w[2:0]];
                default: ;
            endcase
            m_cyc += (w[8:6] == OP_ADD || w[8:6] == OP_SUB) ? 3 + ADD_EXTRA : 3;
            if (m_cnt < 255) m_cnt++;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [25:0] outs();
        return {ProcDIN, ProcRun, MemAddr, Busy, Halted, Fault, InstrCount};
    endfunction

    function automatic logic [8:0] ins(input logic [2:0] op, input int x, input int y);
        return {op, 3'(x), 3'(y)};
    endfunction

    task automatic do_reset();
        @(negedge Clock);
        Resetn = 1'b0; Start = 1'b0; Step = 1'b0; StepNext = 1'b0;
        @(negedge Clock); #1;
        runs = 0; prev_mvi = 1'b0;
        issued_q.delete(); imm_seen_q.delete();
        Resetn = 1'b1;
    endtask

    task automatic clear_rom(input logic [8:0] fill);
        for (int i = 0; i < DEPTH; i++) rom[i] = fill;
    endtask

    task automatic pulse_start(input int sa);
        @(negedge Clock);
        Start = 1'b1; StartAddr = ADDR_W'(sa);
        @(posedge Clock); #1;
        Start = 1'b0;
    endtask

    task automatic wait_run(input int budget, output int n);
        n = 0;
        while (ProcRun !== 1'b1 && n < budget) begin
            @(posedge Clock); #1; n++;
        end
    endtask

    int run_cyc;
    task automatic run_and_check(input string name, input int start);
        int cyc;
        cyc = 0;
        ref_run(start);
        pulse_start(start);
        while (Halted !== 1'b1 && cyc < 600) begin
            @(posedge Clock); #1; cyc++;
        end
        run_cyc = cyc;
        check({name, " halted"}, Halted, 1);
        check({name, " cycles"}, cyc, m_cyc);
        check({name, " count"}, InstrCount, m_cnt);
        @(negedge Clock);
        check({name, " runs"}, runs, m_issue.size());
        check({name, " imm_n"}, imm_seen_q.size(), m_imm.size());
        for (int i = 0; i < m_issue.size() && i < issued_q.size(); i++)
            check({name, " issued"}, issued_q[i], m_issue[i]);
        for (int i = 0; i < m_imm.size() && i < imm_seen_q.size(); i++)
            check({name, " imm"}, imm_seen_q[i], m_imm[i]);
        for (int r = 0; r < 8; r++)
            check({name, " reg"}, creg[r], mreg[r]);
    endtask

    typedef struct packed {
        logic [5:0][8:0] prog;
        logic [7:0]      len;
        logic [4:0]      start;
        logic [7:0]      exp_cnt;
        logic [2:0]      exp_r;
        logic [8:0]      exp_val;
        logic [7:0]      exp_cyc;
    } vec_t;

    function automatic vec_t mk(input logic [8:0] w0, w1, w2, w3, w4, w5,
                                input int len, start, cnt, r, val, cyc);
        vec_t v;
        v.prog    = {w5, w4, w3, w2, w1, w0};
        v.len     = 8'(len);
        v.start   = 5'(start);
        v.exp_cnt = 8'(cnt);
        v.exp_r   = 3'(r);
        v.exp_val = 9'(val);
        v.exp_cyc = 8'(cyc);
        return v;
    endfunction

    initial begin
        vec_t tv [4];
        logic [2:0] ops [7];
        int n, k, len, st, a;

        clear_rom(HALTW);
        tv[0] = mk(ins(OP_MVI,0,0), 9'd5, ins(OP_MVI,1,0), 9'd3, ins(OP_ADD,0,1), HALTW, 6, 0, 3, 0, 8, 23);
        tv[1] = mk(ins(OP_MVI,2,0), 9'd2, ins(OP_SUB,2,2), HALTW, HALTW, HALTW, 4, 0, 2, 2, 0, 16);
        tv[2] = mk(ins(OP_MVI,3,0), 9'd7, HALTW, HALTW, HALTW, HALTW, 3, 31, 1, 3, 7, 9);
        tv[3] = mk(ins(OP_MVI,5,0), 9'h1AB, ins(OP_MV,6,5), 9'b100_001_010, HALTW, HALTW, 5, 12, 3, 6, 9'h1AB, 19);

        // reset state, held in reset
        Resetn = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        check("reset_outputs", outs(), 26'd0);

        // table-driven directed programs
        for (int t = 0; t < 4; t++) begin
            do_reset();
            clear_rom(HALTW);
            for (int i = 0; i < int'(tv[t].len); i++)
                rom[(int'(tv[t].start) + i) % DEPTH] = tv[t].prog[i];
            run_and_check("table", int'(tv[t].start));
            check("table exp_cyc", run_cyc, tv[t].exp_cyc);
            check("table exp_cnt", InstrCount, tv[t].exp_cnt);
            check("table exp_reg", creg[tv[t].exp_r], tv[t].exp_val);
        end

        // single-step
        do_reset();
        clear_rom(HALTW);
        rom[0] = ins(OP_MV,1,0); rom[1] = ins(OP_MV,2,0); rom[2] = ins(OP_MV,3,0);
        Step = 1'b1;
        pulse_start(0);
        wait_run(10, n);
        check("step start_to_run", n, 2);
        @(posedge Clock); #1;
        @(posedge Clock); #1;
        StepNext = 1'b1;                 // arrives in WAIT, must not count
        @(posedge Clock); #1;
        StepNext = 1'b0;
        repeat (8) @(posedge Clock);
        #1;
        check("step pause_runs", runs, 1);
        check("step pause_busy", {Busy, Halted}, 2'b10);
        check("step pause_count", InstrCount, 1);
        StepNext = 1'b1;
        @(posedge Clock); #1;
        StepNext = 1'b0;
        wait_run(10, n);
        check("step next_to_run", n, 2);
        repeat (3) @(posedge Clock);
        repeat (5) @(posedge Clock);
        #1;
        check("step pause2_runs", runs, 2);
        check("step pause2_count", InstrCount, 2);
        Step = 1'b0;
        @(posedge Clock); #1;
        wait_run(10, n);
        check("step clear_to_run", n, 2);
        k = 0;
        while (Halted !== 1'b1 && k < 50) begin
            @(posedge Clock); #1; k++;
        end
        check("step run_to_halt", k, 5);
        check("step final_count", InstrCount, 3);

        // watchdog
        do_reset();
        clear_rom(HALTW);
        rom[0] = ins(OP_MV,1,0);
        stuck0 = 1'b1;
        pulse_start(0);
        wait_run(10, n);
        k = 0;
        while (Fault !== 1'b1 && k < 100) begin
            @(posedge Clock); #1; k++;
        end
        check("wd fault_latency", k, 2 + TIMEOUT);
        check("wd busy_low", Busy, 0);
        pulse_start(0);
        repeat (6) @(posedge Clock);
        #1;
        check("wd fault_sticky", {Fault, Busy}, 2'b10);
        check("wd no_restart", runs, 1);
        @(negedge Clock);
        Resetn = 1'b0;
        @(posedge Clock); #1;
        check("wd reset_outputs", outs(), 26'd0);
        stuck0 = 1'b0;

        // reset during ADD wait, with Start pulsed while busy
        do_reset();
        clear_rom(HALTW);
        rom[0] = ins(OP_MVI,0,0); rom[1] = 9'd5; rom[2] = ins(OP_ADD,0,0);
        rom[10] = ins(OP_MV,7,0);
        pulse_start(0);
        pulse_start(10);
        wait_run(20, n);
        @(posedge Clock); #1;
        wait_run(20, n);
        @(posedge Clock); #1;
        @(posedge Clock); #1;
        check("rst busy_in_wait", {Busy, Halted, ProcDone}, 3'b100);
        check("rst count_before", InstrCount, 1);
        check("rst issued_n", issued_q.size(), 2);
        if (issued_q.size() == 2) begin
            check("rst issued0", issued_q[0], ins(OP_MVI,0,0));
            check("rst issued1", issued_q[1], ins(OP_ADD,0,0));
        end
        Resetn = 1'b0;
        @(posedge Clock); #1;
        check("rst outputs", outs(), 26'd0);
        check("rst core_reg", creg[0], 0);
        Resetn = 1'b1;
        a = runs;
        repeat (5) @(posedge Clock);
        #1;
        check("rst stays_idle", {Busy, 8'(runs - a)}, 9'd0);

        // retired-instruction counter saturation on an endless MV loop
        do_reset();
        clear_rom(ins(OP_MV,0,0));
        pulse_start(0);
        repeat (1320) @(posedge Clock);
        #1;
        check("sat count", InstrCount, 255);
        check("sat busy", Busy, 1);

        // random programs against the reference
        ops = '{OP_MV, OP_MVI, OP_ADD, OP_SUB, 3'b100, 3'b101, 3'b110};
        for (int it = 0; it < 20; it++) begin
            do_reset();
            clear_rom(HALTW);
            st  = int'($urandom_range(DEPTH - 1, 0));
            len = int'($urandom_range(12, 4));
            a = st;
            for (int i = 0; i < len; i++) begin
                logic [2:0] op;
                op = ops[$urandom_range(6, 0)];
                rom[a] = {op, 3'($urandom_range(7, 0)), 3'($urandom_range(7, 0))};
                a = (a + 1) % DEPTH;
                if (op == OP_MVI) begin
                    rom[a] = 9'($urandom_range(511, 0));
                    a = (a + 1) % DEPTH;
                end
            end
            rom[a] = HALTW;
            run_and_check("random", st);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
